// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of pipeline-stage hazard information into the hazard
//               controller and the stall/flush/forward controls it returns.
//               master - pipeline side (drives register indices and status)
//               slave  - hazard controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  // Register indices and status from D/E/M/W
  logic [REG_W-1:0] rs1_d;
  logic [REG_W-1:0] rs2_d;
  logic [REG_W-1:0] rs1_e;
  logic [REG_W-1:0] rs2_e;
  logic [REG_W-1:0] rd_e;
  logic             load_e;
  logic [REG_W-1:0] rd_m;
  logic             reg_write_m;
  logic [REG_W-1:0] rd_w;
  logic             reg_write_w;
  logic             pc_src_e;
  logic             mc_start_e;
  logic             mem_req_m;
  logic             mem_ready;
  // Controls back to the pipeline
  logic [1:0]       forward_a_e;
  logic [1:0]       forward_b_e;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_w;
  logic             mc_done;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, rd_m, reg_write_m,
           rd_w, reg_write_w, pc_src_e, mc_start_e, mem_req_m, mem_ready,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, mc_done
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, rd_m, reg_write_m,
           rd_w, reg_write_w, pc_src_e, mc_start_e, mem_req_m, mem_ready,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, mc_done
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the 5-stage core. Produces operand
//               forwarding selects for EX, per-stage stall/flush for
//               load-use, taken branch/jump, multi-cycle EX ops and data
//               memory wait, and a one-shot pipeline flush after reset.
// Ports       : clk  - core clock
//               rstn - asynchronous active-low reset
//               hz   - hazard_ctrl_if.slave (stage info in, controls out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MC_LATENCY = 4,   // cycles a multi-cycle op spends in EX (2..15)
  parameter int REG_W      = 5
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_W-1:0] X0       = '0;
  localparam logic [3:0]       LAST_CNT = 4'(MC_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rst_flush_q;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall;
  logic       mem_stall;
  logic       last;
  logic       mc_stall;
  logic       stall_e_int;

  // Forwarding: the younger producer in M wins over W; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.reg_write_m && (hz.rd_m != X0) && (hz.rd_m == hz.rs1_e))
      fwd_a = 2'b10;
    else if (hz.reg_write_w && (hz.rd_w != X0) && (hz.rd_w == hz.rs1_e))
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.reg_write_m && (hz.rd_m != X0) && (hz.rd_m == hz.rs2_e))
      fwd_b = 2'b10;
    else if (hz.reg_write_w && (hz.rd_w != X0) && (hz.rd_w == hz.rs2_e))
      fwd_b = 2'b01;
  end

  assign lw_stall  = hz.load_e && (hz.rd_e != X0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  assign mem_stall = hz.mem_req_m && !hz.mem_ready;

  assign last        = (state_q == BUSY) && (cnt_q == LAST_CNT);
  assign mc_stall    = ((state_q == IDLE) && hz.mc_start_e) ||
                       ((state_q == BUSY) && !last);
  assign stall_e_int = mc_stall || mem_stall;

  // Occupancy FSM. The IDLE cycle that sees mc_start_e counts as the first
  // EX cycle, so BUSY runs cnt = 1..MC_LATENCY-1. A memory stall freezes the
  // whole pipeline, including this counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hz.mc_start_e && !mem_stall) begin
          state_d = BUSY;
          cnt_d   = 4'd1;
        end
      end
      BUSY: begin
        if (!mem_stall) begin
          if (last) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rst_flush_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_flush_q <= 1'b0;
    end
  end

  assign hz.forward_a_e = fwd_a;
  assign hz.forward_b_e = fwd_b;

  assign hz.stall_f = lw_stall || stall_e_int;
  assign hz.stall_d = lw_stall || stall_e_int;
  assign hz.stall_e = stall_e_int;
  assign hz.stall_m = mem_stall;

  // A redirect or load bubble held in E by a stall is deferred until E moves.
  assign hz.flush_d = (hz.pc_src_e && !stall_e_int) || rst_flush_q;
  assign hz.flush_e = ((lw_stall || hz.pc_src_e) && !stall_e_int) || rst_flush_q;
  assign hz.flush_m = mc_stall && !mem_stall;
  assign hz.flush_w = mem_stall;

  assign hz.mc_done = last && !mem_stall;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (MC_LATENCY=4).
//               Inputs change on the falling edge; outputs are sampled 1ns
//               later, well clear of the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.REG_W(5)) hz ();

  hazard_ctrl #(
    .MC_LATENCY (4),
    .REG_W      (5)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0;
    hz.rd_e = '0; hz.load_e = 1'b0; hz.rd_m = '0; hz.reg_write_m = 1'b0;
    hz.rd_w = '0; hz.reg_write_w = 1'b0; hz.pc_src_e = 1'b0;
    hz.mc_start_e = 1'b0; hz.mem_req_m = 1'b0; hz.mem_ready = 1'b0;
  endtask

  // Advance to the next falling edge (inputs are then driven, then #1 to sample)
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    // ---------------- reset state
    check("rst_flush_d", 8'(hz.flush_d), 8'd1);
    check("rst_flush_e", 8'(hz.flush_e), 8'd1);
    check("rst_flush_m", 8'(hz.flush_m), 8'd0);
    check("rst_flush_w", 8'(hz.flush_w), 8'd0);
    check("rst_stall_f", 8'(hz.stall_f), 8'd0);
    check("rst_stall_e", 8'(hz.stall_e), 8'd0);
    check("rst_mc_done", 8'(hz.mc_done), 8'd0);

    next_cyc();
    rstn = 1'b1;
    #1;
    check("post_rst_flush_d_c0", 8'(hz.flush_d), 8'd1);
    check("post_rst_flush_e_c0", 8'(hz.flush_e), 8'd1);
    next_cyc(); #1;
    check("post_rst_flush_d_c1", 8'(hz.flush_d), 8'd0);
    check("post_rst_flush_e_c1", 8'(hz.flush_e), 8'd0);

    // ---------------- forwarding
    next_cyc();
    hz.rs1_e = 5'd5; hz.rd_m = 5'd5; hz.reg_write_m = 1'b1;
    hz.rd_w = 5'd5; hz.reg_write_w = 1'b1;
    #1;
    check("fwd_a_m_prio", 8'(hz.forward_a_e), 8'h2);
    hz.rd_m = 5'd0;
    #1;
    check("fwd_a_w_x0m", 8'(hz.forward_a_e), 8'h1);
    hz.rs2_e = 5'd0; hz.rd_w = 5'd0;
    #1;
    check("fwd_b_x0", 8'(hz.forward_b_e), 8'h0);
    hz.rs2_e = 5'd9; hz.rd_m = 5'd9; hz.reg_write_m = 1'b0; hz.rd_w = 5'd9;
    #1;
    check("fwd_b_w_m_nowrite", 8'(hz.forward_b_e), 8'h1);
    hz.reg_write_m = 1'b1;
    #1;
    check("fwd_b_m", 8'(hz.forward_b_e), 8'h2);
    hz.reg_write_w = 1'b0; hz.reg_write_m = 1'b0;
    #1;
    check("fwd_b_none", 8'(hz.forward_b_e), 8'h0);

    // ---------------- load-use
    next_cyc();
    clear_inputs();
    hz.load_e = 1'b1; hz.rd_e = 5'd7; hz.rs2_d = 5'd7;
    #1;
    check("lu_stall_f", 8'(hz.stall_f), 8'd1);
    check("lu_stall_d", 8'(hz.stall_d), 8'd1);
    check("lu_flush_e", 8'(hz.flush_e), 8'd1);
    check("lu_stall_e", 8'(hz.stall_e), 8'd0);
    check("lu_flush_d", 8'(hz.flush_d), 8'd0);
    next_cyc();
    hz.load_e = 1'b0;
    #1;
    check("lu_gone_stall_f", 8'(hz.stall_f), 8'd0);
    hz.load_e = 1'b1; hz.rd_e = 5'd0; hz.rs1_d = 5'd0; hz.rs2_d = 5'd0;
    #1;
    check("lu_x0_stall_f", 8'(hz.stall_f), 8'd0);
    check("lu_x0_flush_e", 8'(hz.flush_e), 8'd0);
    // load-use together with taken branch
    hz.rd_e = 5'd3; hz.rs1_d = 5'd3; hz.pc_src_e = 1'b1;
    #1;
    check("lu_br_flush_d", 8'(hz.flush_d), 8'd1);
    check("lu_br_flush_e", 8'(hz.flush_e), 8'd1);
    check("lu_br_stall_f", 8'(hz.stall_f), 8'd1);

    // ---------------- multi-cycle op, nominal
    next_cyc();
    clear_inputs();
    hz.mc_start_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mc_stall_e_%0d", i), 8'(hz.stall_e), 8'd1);
      check($sformatf("mc_flush_m_%0d", i), 8'(hz.flush_m), 8'd1);
      check($sformatf("mc_done_lo_%0d", i), 8'(hz.mc_done), 8'd0);
      next_cyc();
    end
    #1;
    check("mc_done_c3", 8'(hz.mc_done), 8'd1);
    check("mc_stall_e_c3", 8'(hz.stall_e), 8'd0);
    check("mc_flush_m_c3", 8'(hz.flush_m), 8'd0);

    // ---------------- back-to-back op with a memory wait at cnt=2
    next_cyc();
    #1;
    check("b2b_restart_stall_e", 8'(hz.stall_e), 8'd1);
    check("b2b_restart_done", 8'(hz.mc_done), 8'd0);
    next_cyc();                            // cnt = 1
    next_cyc();                            // cnt = 2
    hz.mem_req_m = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("mw_flush_w_%0d", i), 8'(hz.flush_w), 8'd1);
      check($sformatf("mw_stall_m_%0d", i), 8'(hz.stall_m), 8'd1);
      check($sformatf("mw_flush_m_%0d", i), 8'(hz.flush_m), 8'd0);
      check($sformatf("mw_done_%0d", i), 8'(hz.mc_done), 8'd0);
      next_cyc();
    end
    hz.mem_req_m = 1'b0;
    #1;
    // cnt still 2 after the frozen cycles
    check("mw_resume_stall_e", 8'(hz.stall_e), 8'd1);
    check("mw_resume_flush_m", 8'(hz.flush_m), 8'd1);
    check("mw_resume_done", 8'(hz.mc_done), 8'd0);
    next_cyc();
    #1;
    check("mw_late_done", 8'(hz.mc_done), 8'd1);
    next_cyc();
    hz.mc_start_e = 1'b0;
    #1;
    check("mw_idle_stall_e", 8'(hz.stall_e), 8'd0);
    check("mw_idle_done", 8'(hz.mc_done), 8'd0);

    // ---------------- taken branch held by memory stall
    next_cyc();
    hz.pc_src_e = 1'b1; hz.mem_req_m = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("brm_flush_d_%0d", i), 8'(hz.flush_d), 8'd0);
      check($sformatf("brm_flush_e_%0d", i), 8'(hz.flush_e), 8'd0);
      next_cyc();
    end
    hz.mem_ready = 1'b1;
    #1;
    check("brm_rel_flush_d", 8'(hz.flush_d), 8'd1);
    check("brm_rel_flush_e", 8'(hz.flush_e), 8'd1);
    check("brm_rel_stall_m", 8'(hz.stall_m), 8'd0);

    // ---------------- reset in the middle of a multi-cycle op
    next_cyc();
    clear_inputs();
    hz.mc_start_e = 1'b1;
    next_cyc();                            // cnt = 1
    next_cyc();                            // cnt = 2
    #1;
    check("rb_busy_stall_e", 8'(hz.stall_e), 8'd1);
    #1;
    rstn = 1'b0;
    hz.mc_start_e = 1'b0;
    #1;
    check("rb_abort_stall_e", 8'(hz.stall_e), 8'd0);
    check("rb_abort_done", 8'(hz.mc_done), 8'd0);
    check("rb_abort_flush_d", 8'(hz.flush_d), 8'd1);
    next_cyc();
    rstn = 1'b1;
    #1;
    check("rb_rel_flush_d_c0", 8'(hz.flush_d), 8'd1);
    check("rb_rel_flush_e_c0", 8'(hz.flush_e), 8'd1);
    next_cyc();
    #1;
    check("rb_rel_flush_d_c1", 8'(hz.flush_d), 8'd0);
    check("rb_rel_flush_e_c1", 8'(hz.flush_e), 8'd0);
    check("rb_rel_done", 8'(hz.mc_done), 8'd0);
    check("rb_rel_stall_e", 8'(hz.stall_e), 8'd0);
    next_cyc();
    #1;
    check("rb_rel_done_c2", 8'(hz.mc_done), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core; drives the `forward_a_e`/`forward_b_e` selects and `rs1`/`rs2` matching consumed by the execute stage.
- Generates per-stage stall/flush for load-use, taken branch/jump, multi-cycle execute ops and data-memory wait.
- Owns the multi-cycle execute occupancy FSM and a post-reset pipeline flush.

Parameters:
- MC_LATENCY, 4, cycles a multi-cycle op occupies EX (legal range 2..15).
- REG_W, 5, register index width.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- rs1_d  input  REG_W  source 1 of instruction in D
- rs2_d  input  REG_W  source 2 of instruction in D
- rs1_e  input  REG_W  source 1 of instruction in E
- rs2_e  input  REG_W  source 2 of instruction in E
- rd_e  input  REG_W  destination of instruction in E
- load_e  input  1  instruction in E is a load
- rd_m  input  REG_W  destination in M
- reg_write_m  input  1  M writes register file
- rd_w  input  REG_W  destination in W
- reg_write_w  input  1  W writes register file
- pc_src_e  input  1  branch taken / jump in E
- mc_start_e  input  1  instruction in E is a multi-cycle op
- mem_req_m  input  1  M performs a data-memory access
- mem_ready  input  1  data memory completes this cycle
- forward_a_e  output  2  src_a select: 00 rd1, 01 result_w, 10 alu_result_m
- forward_b_e  output  2  write_data/src_b select, same encoding
- stall_f, stall_d, stall_e, stall_m  output  1 each  hold stage register
- flush_d, flush_e, flush_m, flush_w  output  1 each  load bubble into stage register
- mc_done  output  1  multi-cycle result valid in EX this cycle

Behaviour:
- Forwarding (combinational), per source X in {1,2}:
  - 10 if `reg_write_m` && `rd_m` != 0 && `rd_m` == `rsX_e`;
  - else 01 if `reg_write_w` && `rd_w` != 0 && `rd_w` == `rsX_e`;
  - else 00.
  - M has priority over W. x0 is never forwarded. Code 11 is never driven.
- `lw_stall` = `load_e` && `rd_e` != 0 && (`rd_e` == `rs1_d` || `rd_e` == `rs2_d`).
- `mem_stall` = `mem_req_m` && !`mem_ready`.
- MC FSM, states IDLE/BUSY, 4-bit counter `cnt`:
  - IDLE, `mc_start_e` && !`mem_stall` -> BUSY, `cnt` = 1.
  - BUSY, `mem_stall` -> hold state and `cnt` (frozen).
  - BUSY, `cnt` == MC_LATENCY-1 && !`mem_stall` -> IDLE.
  - BUSY, otherwise -> `cnt`+1.
  - `mc_start_e` is ignored in BUSY (same held instruction).
  - `last` = BUSY && `cnt` == MC_LATENCY-1.
  - `mc_stall` = (IDLE && `mc_start_e`) || (BUSY && !`last`).
  - `mc_done` = `last` && !`mem_stall`.
  - An op occupies EX exactly MC_LATENCY cycles absent memory stalls. A back-to-back mc op restarts from IDLE on the following cycle.
- `rst_flush` register: set to 1 during reset, cleared on the first clk edge after `rstn` rises.
- Stall/flush equations:
  - `stall_f` = `stall_d` = `lw_stall` || `mc_stall` || `mem_stall`
  - `stall_e` = `mc_stall` || `mem_stall`
  - `stall_m` = `mem_stall`
  - `flush_d` = (`pc_src_e` && !`stall_e`) || `rst_flush`
  - `flush_e` = ((`lw_stall` || `pc_src_e`) && !`stall_e`) || `rst_flush`
  - `flush_m` = `mc_stall` && !`mem_stall`
  - `flush_w` = `mem_stall`
- Taken branch held in E by `mem_stall` defers its flush until the stall clears. `pc_src_e` is re-sampled each cycle.
- Load-use and taken branch in the same cycle: `flush_d`=1, `flush_e`=1, `stall_f`=`stall_d`=1. The redirect wins because D is flushed.
- Reset values (`rstn`=0): state IDLE, `cnt`=0, `mc_done`=0, all stall_*=0 (inputs permitting), `flush_d`=`flush_e`=1, `flush_m`=`flush_w`=0.
- Reset mid-BUSY aborts the op immediately; no `mc_done` is issued.

Test Plan:
- Forwarding: `rs1_e`=5, `rd_m`=5, `reg_write_m`=1, `rd_w`=5, `reg_write_w`=1 -> `forward_a_e`=10. Same with `rd_m`=0 -> 01. `rs2_e`=0 with all matches -> `forward_b_e`=00.
- Load-use: `load_e`=1, `rd_e`=7, `rs2_d`=7 -> `stall_f`=`stall_d`=1, `flush_e`=1, `stall_e`=0 for one cycle. With `rd_e`=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: `mc_start_e` pulse held -> `stall_e`=1 for 3 cycles, `flush_m`=1 for 3 cycles, `mc_done`=1 on cycle 4 only, state back to IDLE.
- Memory wait during BUSY: `mem_stall` asserted 2 cycles at `cnt`=2 -> `cnt` frozen, `flush_w`=1, `stall_m`=1, `flush_m`=0 for 2 cycles. `mc_done` arrives 2 cycles later than nominal.
- Branch under memory stall: `pc_src_e`=1 with `mem_req_m`=1, `mem_ready`=0 for 3 cycles -> `flush_d`=`flush_e`=0 for 3 cycles, then 1 on the cycle `mem_ready`=1.
- Reset: deassert `rstn` while BUSY at `cnt`=2 -> state IDLE, `mc_done`=0. After release, `flush_d`=`flush_e`=1 for exactly one cycle.
